sram_like_responder: RTL and testbench
======================================

SRAM_LIKE_RESPONDER -- requirements
Module: sram_like_responder

Interface
REQ-001 SHALL have parameter AW, default 10: log2 of backing word-array depth (1024 x 32-bit words).
REQ-002 SHALL have parameter DEPTH, default 2: maximum outstanding accepted requests (power of 2, 1..8).
REQ-003 SHALL have parameter LATENCY, default 2: minimum cycles from accept to data_ok (1..15).
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port resetn  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  1  initiator request valid.
REQ-007 SHALL have port wr  input  1  1 = write, 0 = read.
REQ-008 SHALL have port size  input  2  access size; ignored, lanes come from wstrb.
REQ-009 SHALL have port wstrb  input  4  write byte enables.
REQ-010 SHALL have port addr  input  32  byte address; word index = addr[AW+1:2].
REQ-011 SHALL have port wdata  input  32  write data.
REQ-012 SHALL have port addr_ok  output  1  request accepted this cycle when high with req.
REQ-013 SHALL have port data_ok  output  1  one-cycle completion pulse for the head request.
REQ-014 SHALL have port rdata  output  32  read word, valid only while data_ok is high.

Function
REQ-015 SHALL accept a request in every cycle where req and addr_ok are both high; wr, wstrb, word index and wdata are captured into the tail of an in-order FIFO.
REQ-016 SHALL drive addr_ok combinationally as req AND (count < DEPTH); there is no bypass when full, so a retire in the same cycle does not reopen a full FIFO.
REQ-017 SHALL load each entry's down-counter with LATENCY-1 on accept and decrement it on every edge while it is nonzero.
REQ-018 SHALL assert data_ok for exactly one cycle when the head entry is valid and its counter is 0; at LATENCY=1, an accept in cycle T gives data_ok in T+1.
REQ-019 SHALL complete requests strictly in acceptance order, reads and writes alike, and SHALL produce exactly one data_ok per accepted request.
REQ-020 SHALL perform a head write on its data_ok edge, updating only the bytes enabled by wstrb; wstrb=0 still produces data_ok.
REQ-021 SHALL drive rdata with array[head word index] for a head read during its data_ok cycle; a read therefore observes every earlier-accepted write.
REQ-022 SHALL drive rdata to 0 whenever data_ok is low or the head is a write.
REQ-023 SHALL silently ignore addr bits above AW+1 and addr[1:0], so addresses wrap.
REQ-024 SHALL, when an accept and a retire occur in the same cycle, leave count unchanged and advance both pointers.
REQ-025 SHALL allow back-to-back data_ok pulses when successive head entries have already expired.

Reset
REQ-026 SHALL, while resetn is low, empty the FIFO, zero the pointers, count and counters, and hold data_ok=0, rdata=0 and addr_ok=0.
REQ-027 SHALL discard in-flight requests on a reset mid-operation, producing no data_ok and no write for them.
REQ-028 SHALL NOT reset the word array.

Configuration
REQ-029 SHALL, when RANDOM_DELAY_EN is defined, run a 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 0xACE1 on reset) that advances every cycle.
REQ-030 SHALL, under RANDOM_DELAY_EN, force addr_ok low in cycles where LFSR bit0=1, and suppress the head retire in cycles where LFSR bit1=1; ordering and one-pulse-per-request rules still hold.
REQ-031 SHALL, when RANDOM_DELAY_EN is undefined, have no LFSR and show timing exactly per REQ-016 and REQ-018.

Verification
REQ-032 SHALL cover: LATENCY=2, write addr=0x10 wdata=0xDEADBEEF wstrb=0xF, then read 0x10 -> two data_ok pulses in order, with rdata=0xDEADBEEF on the second.
REQ-033 SHALL cover: partial write wstrb=0x2 wdata=0x0000AB00 over 0x11223344 -> read returns 0x1122AB44.
REQ-034 SHALL cover: DEPTH=2, req held high with no retire possible (LATENCY=4) -> addr_ok high for 2 cycles, then low until the first data_ok, then high again.
REQ-035 SHALL cover: read 0x20 accepted before a write of 0x55 to 0x20 -> the read returns the old value, and a later read returns 0x55.
REQ-036 SHALL cover: resetn dropped with 2 outstanding requests -> no data_ok after release and no array update from the dropped write.
REQ-037 SHALL cover: addr=0x00001010 with AW=10 -> aliases word index 0x004, same as addr 0x10.

Source files
------------

// File: rtl/sram_like_responder.sv
// sram_like_responder: SRAM-like slave with an in-order request FIFO and a
// 2**AW x 32-bit backing array. Each accepted request completes with exactly
// one data_ok pulse, at least LATENCY cycles after it was accepted.
// Optional build macro RANDOM_DELAY_EN adds LFSR-driven back-pressure and
// retire stalls.
module sram_like_responder #(
  parameter int AW      = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [3:0]  wstrb,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        addr_ok,
  output logic        data_ok,
  output logic [31:0] rdata
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int LW = 4;

  // Request FIFO: control state is reset, payload is not
  logic [DEPTH-1:0] valid_q;
  logic [LW-1:0]    cnt_q   [DEPTH];
  logic             wr_q    [DEPTH];
  logic [3:0]       strb_q  [DEPTH];
  logic [AW-1:0]    idx_q   [DEPTH];
  logic [31:0]      wdata_q [DEPTH];

  logic [PW-1:0] head_q;
  logic [PW-1:0] tail_q;
  logic [CW-1:0] count_q;

  logic [31:0] mem [2**AW];

  logic          accept;
  logic          retire;
  logic          gate_accept;
  logic          gate_retire;
  logic          head_wr;
  logic [3:0]    head_strb;
  logic [AW-1:0] head_idx;
  logic [31:0]   head_wdata;
  logic [AW-1:0] req_idx;

  // size and the ignored address bits are intentionally dropped
  logic unused_bits;
  assign unused_bits = ^{size, addr[31:AW+2], addr[1:0]};

  assign req_idx = addr[AW+1:2];

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

`ifdef RANDOM_DELAY_EN
  logic [15:0] lfsr_q;

  // Free-running Fibonacci LFSR, taps 16,14,13,11
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) lfsr_q <= 16'hACE1;
    else         lfsr_q <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
  end

  assign gate_accept = ~lfsr_q[0];
  assign gate_retire = ~lfsr_q[1];
`else
  assign gate_accept = 1'b1;
  assign gate_retire = 1'b1;
`endif

  // Head entry decode
  always_comb begin
    head_wr    = wr_q[head_q];
    head_strb  = strb_q[head_q];
    head_idx   = idx_q[head_q];
    head_wdata = wdata_q[head_q];
  end

  // Handshake: no bypass when full; head retires once its counter expires
  always_comb begin
    addr_ok = resetn & req & (count_q < CW'(DEPTH)) & gate_accept;
    data_ok = valid_q[head_q] & (cnt_q[head_q] == '0) & gate_retire;
    accept  = addr_ok;
    retire  = data_ok;
  end

  // Pointers and occupancy
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (accept) tail_q <= next_ptr(tail_q);
      if (retire) head_q <= next_ptr(head_q);
      case ({accept, retire})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Per-entry valid flags and latency down-counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      valid_q <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (accept && (tail_q == PW'(i))) begin
          valid_q[i] <= 1'b1;
          cnt_q[i]   <= LW'(LATENCY - 1);
        end else begin
          if (retire && (head_q == PW'(i))) valid_q[i] <= 1'b0;
          if (cnt_q[i] != '0) cnt_q[i] <= cnt_q[i] - 1'b1;
        end
      end
    end
  end

  // Request payload capture at the tail
  always_ff @(posedge clk) begin
    if (accept) begin
      wr_q[tail_q]    <= wr;
      strb_q[tail_q]  <= wstrb;
      idx_q[tail_q]   <= req_idx;
      wdata_q[tail_q] <= wdata;
    end
  end

  // Byte-masked array write on the head write's completion edge
  always_ff @(posedge clk) begin
    if (retire && head_wr) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (head_strb[b]) mem[head_idx][8*b +: 8] <= head_wdata[8*b +: 8];
      end
    end
  end

  // Read data only during a head read's completion cycle
  always_comb begin
    rdata = '0;
    if (data_ok && !head_wr) rdata = mem[head_idx];
  end

endmodule

// File: tb/tb_sram_like_responder.sv
// Directed bench for sram_like_responder: one instance at default parameters
// and one at LATENCY=4 for the back-pressure scenario.
module tb_sram_like_responder;

  logic        clk = 1'b0;
  logic        resetn;

  logic        req_a, wr_a;
  logic [1:0]  size_a;
  logic [3:0]  strb_a;
  logic [31:0] addr_a, wdata_a;
  logic        ok_a, dok_a;
  logic [31:0] rd_a;

  logic        req_b, wr_b;
  logic [1:0]  size_b;
  logic [3:0]  strb_b;
  logic [31:0] addr_b, wdata_b;
  logic        ok_b, dok_b;
  logic [31:0] rd_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sram_like_responder #(.AW(10), .DEPTH(2), .LATENCY(2)) u_dut_a (
    .clk(clk), .resetn(resetn), .req(req_a), .wr(wr_a), .size(size_a),
    .wstrb(strb_a), .addr(addr_a), .wdata(wdata_a),
    .addr_ok(ok_a), .data_ok(dok_a), .rdata(rd_a)
  );

  sram_like_responder #(.AW(10), .DEPTH(2), .LATENCY(4)) u_dut_b (
    .clk(clk), .resetn(resetn), .req(req_b), .wr(wr_b), .size(size_b),
    .wstrb(strb_b), .addr(addr_b), .wdata(wdata_b),
    .addr_ok(ok_b), .data_ok(dok_b), .rdata(rd_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One cycle on instance A: drive at negedge, check outputs 1 time unit later
  task automatic ca(input logic r, input logic w, input logic [31:0] a,
                    input logic [31:0] d, input logic [3:0] s,
                    input logic eok, input logic edok, input logic [31:0] erd,
                    input string tag);
    @(negedge clk);
    req_a = r; wr_a = w; addr_a = a; wdata_a = d; strb_a = s;
    #1;
    chk({tag, ".addr_ok"}, {31'b0, ok_a}, {31'b0, eok});
    chk({tag, ".data_ok"}, {31'b0, dok_a}, {31'b0, edok});
    chk({tag, ".rdata"}, rd_a, erd);
  endtask

  // One cycle on instance B (zero-strobe writes only, so rdata stays 0)
  task automatic cb(input logic r, input logic eok, input logic edok, input string tag);
    @(negedge clk);
    req_b = r; wr_b = 1'b1; addr_b = 32'h0; wdata_b = 32'h0; strb_b = 4'h0;
    #1;
    chk({tag, ".addr_ok"}, {31'b0, ok_b}, {31'b0, eok});
    chk({tag, ".data_ok"}, {31'b0, dok_b}, {31'b0, edok});
    chk({tag, ".rdata"}, rd_b, 32'h0);
  endtask

  initial begin
    resetn = 1'b0;
    req_a = 1'b1; wr_a = 1'b0; size_a = 2'b10; strb_a = 4'h0; addr_a = '0; wdata_a = '0;
    req_b = 1'b1; wr_b = 1'b0; size_b = 2'b10; strb_b = 4'h0; addr_b = '0; wdata_b = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.addr_ok_a", {31'b0, ok_a}, 32'h0);
    chk("rst.data_ok_a", {31'b0, dok_a}, 32'h0);
    chk("rst.rdata_a", rd_a, 32'h0);
    chk("rst.addr_ok_b", {31'b0, ok_b}, 32'h0);
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0;
    resetn = 1'b1;

    // Full write then read of the same word, back-to-back completions
    ca(1, 1, 32'h10, 32'hDEADBEEF, 4'hF, 1, 0, 32'h0,        "t1c0");
    ca(1, 0, 32'h10, 32'h0,        4'h0, 1, 0, 32'h0,        "t1c1");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h0,        "t1c2");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'hDEADBEEF, "t1c3");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t1c4");

    // Partial-lane write; full FIFO refuses, then accept+retire together
    ca(1, 1, 32'h40, 32'h11223344, 4'hF, 1, 0, 32'h0,        "t2c0");
    ca(1, 1, 32'h40, 32'h0000AB00, 4'h2, 1, 0, 32'h0,        "t2c1");
    ca(1, 0, 32'h40, 32'h0,        4'h0, 0, 1, 32'h0,        "t2c2");
    ca(1, 0, 32'h40, 32'h0,        4'h0, 1, 1, 32'h0,        "t2c3");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t2c4");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h1122AB44, "t2c5");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t2c6");

    // Read accepted before a write sees the old value; later read sees new
    ca(1, 1, 32'h20, 32'h000000AA, 4'hF, 1, 0, 32'h0,        "t3c0");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t3c1");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h0,        "t3c2");
    ca(1, 0, 32'h20, 32'h0,        4'h0, 1, 0, 32'h0,        "t3c3");
    ca(1, 1, 32'h20, 32'h00000055, 4'hF, 1, 0, 32'h0,        "t3c4");
    ca(1, 0, 32'h20, 32'h0,        4'h0, 0, 1, 32'h000000AA, "t3c5");
    ca(1, 0, 32'h20, 32'h0,        4'h0, 1, 1, 32'h0,        "t3c6");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t3c7");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h00000055, "t3c8");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t3c9");

    // Aliased address 0x1010 hits word 4, same as 0x10
    ca(1, 1, 32'h00001010, 32'hCAFEF00D, 4'hF, 1, 0, 32'h0,  "t4c0");
    ca(1, 0, 32'h10, 32'h0,        4'h0, 1, 0, 32'h0,        "t4c1");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h0,        "t4c2");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'hCAFEF00D, "t4c3");

    // Zero-strobe write completes but leaves the word untouched
    ca(1, 1, 32'h10, 32'h0,        4'h0, 1, 0, 32'h0,        "t5c0");
    ca(1, 0, 32'h10, 32'h0,        4'h0, 1, 0, 32'h0,        "t5c1");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h0,        "t5c2");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'hCAFEF00D, "t5c3");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t5c4");

    // Reset with two requests in flight drops them and their write
    ca(1, 1, 32'h30, 32'h12345678, 4'hF, 1, 0, 32'h0,        "t6c0");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t6c1");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h0,        "t6c2");
    ca(1, 1, 32'h30, 32'hFFFFFFFF, 4'hF, 1, 0, 32'h0,        "t6c3");
    ca(1, 0, 32'h30, 32'h0,        4'h0, 1, 0, 32'h0,        "t6c4");
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("t6.rst.addr_ok", {31'b0, ok_a}, 32'h0);
    chk("t6.rst.data_ok", {31'b0, dok_a}, 32'h0);
    chk("t6.rst.rdata", rd_a, 32'h0);
    @(negedge clk);
    req_a = 1'b0;
    resetn = 1'b1;
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t6c5");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t6c6");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t6c7");
    ca(1, 0, 32'h30, 32'h0,        4'h0, 1, 0, 32'h0,        "t6c8");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t6c9");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 1, 32'h12345678, "t6c10");
    ca(0, 0, 32'h0,  32'h0,        4'h0, 0, 0, 32'h0,        "t6c11");

    // LATENCY=4, DEPTH=2: req held high fills the FIFO and stalls
    cb(1, 1, 0, "t7c0");
    cb(1, 1, 0, "t7c1");
    cb(1, 0, 0, "t7c2");
    cb(1, 0, 0, "t7c3");
    cb(1, 0, 1, "t7c4");
    cb(1, 1, 1, "t7c5");
    cb(1, 1, 0, "t7c6");
    cb(1, 0, 0, "t7c7");
    cb(0, 0, 0, "t7c8");
    cb(0, 0, 1, "t7c9");
    cb(0, 0, 1, "t7c10");
    cb(0, 0, 0, "t7c11");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
